// File: rtl/cluster_sched_pkg.sv
// Shared constants and state encoding for the cluster bit scheduler.
package cluster_sched_pkg;

   localparam int DEF_IN_W  = 1894;
   localparam int DEF_OUT_W = 128;
   localparam int DEF_LANES = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_EVAL = 2'd1;
   localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/cluster_bit_collector.sv
// Output-bit register: one LANES-wide lane group is written per cycle at
// wr_idx; clear wipes the whole vector at the start of a transaction.
module cluster_bit_collector
   import cluster_sched_pkg::*;
#(
   parameter int OUT_W = DEF_OUT_W,
   parameter int LANES = DEF_LANES,
   parameter int IDX_W = $clog2(DEF_OUT_W / DEF_LANES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [LANES-1:0] wr_bits,
   output logic [OUT_W-1:0] out_vec
);

   // Clear has priority so a fresh transaction never sees stale groups
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vec <= {OUT_W{1'b0}};
      end else if (clear) begin
         out_vec <= {OUT_W{1'b0}};
      end else if (wr_en) begin
         out_vec[wr_idx*LANES +: LANES] <= wr_bits;
      end
   end

endmodule

// File: rtl/cluster_bit_scheduler.sv
// Cluster bit scheduler: latches one input vector, steps a shared evaluator
// bank across OUT_W/LANES lane groups and presents the assembled output bits.
module cluster_bit_scheduler
   import cluster_sched_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int OUT_W = DEF_OUT_W,
   parameter int LANES = DEF_LANES
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [IN_W-1:0]                   in_vec,
   input  logic                              flush,
   output logic [IN_W-1:0]                   eval_vec,
   output logic [$clog2(OUT_W/LANES)-1:0]    eval_idx,
   input  logic [LANES-1:0]                  eval_bits,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [OUT_W-1:0]                  out_vec,
   output logic                              busy
);

   localparam int GROUPS = OUT_W / LANES;
   localparam int IDX_W  = $clog2(GROUPS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUPS - 1);

   generate
      if (((OUT_W % LANES) != 0) || (LANES > OUT_W)) begin : g_bad_cfg
         $error("cluster_bit_scheduler: OUT_W must be a multiple of LANES and LANES <= OUT_W");
      end
   endgenerate

   state_t state;
   state_t state_nxt;
   logic   accept;
   logic   wr_en;

   // Next-state decode; flush outranks every other event in every state
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (flush) begin
               state_nxt = ST_IDLE;
            end else if (in_valid && in_ready) begin
               accept    = 1'b1;
               state_nxt = ST_EVAL;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_EVAL: begin
            if (flush) begin
               state_nxt = ST_IDLE;
            end else if (eval_idx == LAST_IDX) begin
               state_nxt = ST_DONE;
            end else begin
               state_nxt = ST_EVAL;
            end
         end
         ST_DONE: begin
            if (flush || out_ready) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_DONE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign wr_en = (state == ST_EVAL) && !flush;

   // State register with handshake flags registered from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         in_ready  <= (state_nxt == ST_IDLE);
         busy      <= (state_nxt != ST_IDLE);
         out_valid <= (state_nxt == ST_DONE);
      end
   end

   // Lane-group index; restarts on acceptance or abort, wraps after the last group
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eval_idx <= {IDX_W{1'b0}};
      end else if (accept || flush) begin
         eval_idx <= {IDX_W{1'b0}};
      end else if (state == ST_EVAL) begin
         eval_idx <= (eval_idx == LAST_IDX) ? {IDX_W{1'b0}} : eval_idx + 1'b1;
      end
   end

   // Evaluator operand is a register so in_vec never reaches the bank combinationally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eval_vec <= {IN_W{1'b0}};
      end else if (accept) begin
         eval_vec <= in_vec;
      end
   end

   cluster_bit_collector #(
      .OUT_W (OUT_W),
      .LANES (LANES),
      .IDX_W (IDX_W)
   ) u_collector (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (accept),
      .wr_en   (wr_en),
      .wr_idx  (eval_idx),
      .wr_bits (eval_bits),
      .out_vec (out_vec)
   );

endmodule

// File: tb/tb_cluster_bit_scheduler.sv
// Directed bench for cluster_bit_scheduler; the evaluator model returns
// output bit k = eval_vec[k], optionally inverted to prove it is ignored.
module tb_cluster_bit_scheduler;
   import cluster_sched_pkg::*;

   localparam int IN_W   = DEF_IN_W;
   localparam int OUT_W  = DEF_OUT_W;
   localparam int LANES  = DEF_LANES;
   localparam int GROUPS = OUT_W / LANES;
   localparam int IDX_W  = $clog2(GROUPS);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             flush = 1'b0;
   logic             out_ready = 1'b0;
   logic             corrupt = 1'b0;
   logic [IN_W-1:0]  in_vec = {IN_W{1'b0}};
   logic             in_ready;
   logic [IN_W-1:0]  eval_vec;
   logic [IDX_W-1:0] eval_idx;
   logic [LANES-1:0] eval_bits;
   logic             out_valid;
   logic [OUT_W-1:0] out_vec;
   logic             busy;

   int checks = 0;
   int errors = 0;

   cluster_bit_scheduler #(.IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .flush     (flush),
      .eval_vec  (eval_vec),
      .eval_idx  (eval_idx),
      .eval_bits (eval_bits),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_vec   (out_vec),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   assign eval_bits = eval_vec[eval_idx*LANES +: LANES] ^ {LANES{corrupt}};

   function automatic logic [IN_W-1:0] fill(input logic [31:0] w);
      logic [IN_W-1:0] v;
      for (int k = 0; k < IN_W; k++) v[k] = w[k % 32];
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept_vec(input logic [IN_W-1:0] v);
      in_vec = v;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      #3;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL reset flags: in_ready %0b busy %0b out_valid %0b, expected 1 0 0", in_ready, busy, out_valid);
      end
      checks++; if (eval_idx !== {IDX_W{1'b0}}) begin
         errors++; $display("FAIL reset eval_idx: got %0d expected 0", eval_idx);
      end
      checks++; if (out_vec !== {OUT_W{1'b0}} || eval_vec !== {IN_W{1'b0}}) begin
         errors++; $display("FAIL reset vectors: out_vec %h eval_vec low %h, expected zero", out_vec, eval_vec[OUT_W-1:0]);
      end
   endtask

   task automatic test_single();
      logic [IN_W-1:0]  v;
      logic [OUT_W-1:0] exp;
      v = fill(32'hA5A5_A5A5);
      exp = v[OUT_W-1:0];
      out_ready = 1'b0;
      accept_vec(v);
      checks++; if (eval_vec !== v || busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL single accept: eval_vec low %h busy %0b in_ready %0b, expected %h 1 0", eval_vec[OUT_W-1:0], busy, in_ready, exp);
      end
      checks++; if (out_vec !== {OUT_W{1'b0}}) begin
         errors++; $display("FAIL single clear: out_vec %h expected 0", out_vec);
      end
      for (int i = 0; i < GROUPS; i++) begin
         checks++; if (eval_idx !== IDX_W'(i) || out_valid !== 1'b0) begin
            errors++; $display("FAIL single idx step %0d: eval_idx %0d out_valid %0b, expected %0d 0", i, eval_idx, out_valid, i);
         end
         tick();
      end
      checks++; if (out_valid !== 1'b1) begin
         errors++; $display("FAIL single latency: out_valid %0b at cycle 33, expected 1", out_valid);
      end
      checks++; if (eval_idx !== {IDX_W{1'b0}}) begin
         errors++; $display("FAIL single wrap: eval_idx %0d expected 0", eval_idx);
      end
      checks++; if (out_vec !== exp) begin
         errors++; $display("FAIL single out_vec: got %h expected %h", out_vec, exp);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL single transfer: out_valid %0b in_ready %0b busy %0b, expected 0 1 0", out_valid, in_ready, busy);
      end
      checks++; if (out_vec !== exp) begin
         errors++; $display("FAIL single hold after transfer: got %h expected %h", out_vec, exp);
      end
   endtask

   task automatic test_backpressure();
      logic [IN_W-1:0]  v;
      logic [IN_W-1:0]  v2;
      logic [OUT_W-1:0] exp;
      int               bad;
      v = fill(32'h3C96_0F1E);
      v2 = fill(32'hDEAD_BEEF);
      exp = v[OUT_W-1:0];
      out_ready = 1'b0;
      accept_vec(v);
      wait_valid();
      corrupt = 1'b1;
      in_vec = v2;
      in_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (out_valid !== 1'b1 || out_vec !== exp || eval_vec !== v || in_ready !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin
         errors++; $display("FAIL backpressure hold: %0d unstable cycles, out_vec %h expected %h", bad, out_vec, exp);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || eval_vec !== v) begin
         errors++; $display("FAIL backpressure transfer: out_valid %0b busy %0b eval_vec low %h, expected 0 0 %h", out_valid, busy, eval_vec[OUT_W-1:0], exp);
      end
      in_valid = 1'b0;
      corrupt = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [IN_W-1:0] vc;
      logic [IN_W-1:0] vd;
      int cyc, ov1, acc2, ov2, done2;
      vc = fill(32'h1234_5678);
      vd = fill(32'hFEDC_BA98);
      ov1 = 0; acc2 = 0; ov2 = 0; done2 = 0;
      out_ready = 1'b1;
      in_vec = vc;
      in_valid = 1'b1;
      tick();
      cyc = 1;
      in_vec = vd;
      for (int n = 0; n < 100 && done2 == 0; n++) begin
         tick();
         cyc++;
         if (out_valid === 1'b1 && ov1 == 0) begin
            ov1 = cyc;
            checks++; if (out_vec !== vc[OUT_W-1:0]) begin
               errors++; $display("FAIL b2b first out_vec: got %h expected %h", out_vec, vc[OUT_W-1:0]);
            end
         end else if (acc2 == 0 && ov1 != 0 && busy === 1'b1 && out_valid === 1'b0) begin
            acc2 = cyc;
            in_valid = 1'b0;
         end else if (acc2 != 0 && out_valid === 1'b1 && ov2 == 0) begin
            ov2 = cyc;
            checks++; if (out_vec !== vd[OUT_W-1:0]) begin
               errors++; $display("FAIL b2b second out_vec: got %h expected %h", out_vec, vd[OUT_W-1:0]);
            end
         end else if (ov2 != 0 && out_valid === 1'b0) begin
            done2 = cyc;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      checks++; if (ov1 != 33 || acc2 != 35) begin
         errors++; $display("FAIL b2b first timing: out_valid cycle %0d accept2 cycle %0d, expected 33 35", ov1, acc2);
      end
      checks++; if (ov2 != 67 || done2 != 68) begin
         errors++; $display("FAIL b2b second timing: out_valid cycle %0d end cycle %0d, expected 67 68", ov2, done2);
      end
   endtask

   task automatic test_flush();
      logic [IN_W-1:0] ve;
      logic [IN_W-1:0] vf;
      int              seen;
      ve = fill(32'h0F0F_F0F0);
      vf = fill(32'h5A3C_C3A5);
      accept_vec(ve);
      for (int i = 0; i < 17; i++) tick();
      checks++; if (eval_idx !== IDX_W'(17)) begin
         errors++; $display("FAIL flush setup: eval_idx %0d expected 17", eval_idx);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || eval_idx !== {IDX_W{1'b0}}) begin
         errors++; $display("FAIL flush eval: busy %0b in_ready %0b out_valid %0b idx %0d, expected 0 1 0 0", busy, in_ready, out_valid, eval_idx);
      end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (out_valid === 1'b1) seen++;
      end
      checks++; if (seen != 0) begin
         errors++; $display("FAIL flush no output: out_valid seen %0d cycles, expected 0", seen);
      end
      accept_vec(vf);
      checks++; if (out_vec !== {OUT_W{1'b0}}) begin
         errors++; $display("FAIL flush stale clear: out_vec %h expected 0", out_vec);
      end
      wait_valid();
      checks++; if (out_valid !== 1'b1 || out_vec !== vf[OUT_W-1:0]) begin
         errors++; $display("FAIL flush next txn: out_valid %0b out_vec %h expected 1 %h", out_valid, out_vec, vf[OUT_W-1:0]);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL flush done: out_valid %0b busy %0b expected 0 0", out_valid, busy);
      end
      in_vec = ve;
      in_valid = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      checks++; if (busy !== 1'b0 || eval_vec !== vf) begin
         errors++; $display("FAIL flush idle priority: busy %0b eval_vec low %h expected 0 %h", busy, eval_vec[OUT_W-1:0], vf[OUT_W-1:0]);
      end
   endtask

   task automatic test_async_reset();
      logic [IN_W-1:0] vg;
      int              seen;
      vg = fill(32'h7777_8888);
      accept_vec(vg);
      for (int i = 0; i < 31; i++) tick();
      checks++; if (eval_idx !== IDX_W'(31)) begin
         errors++; $display("FAIL areset setup: eval_idx %0d expected 31", eval_idx);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || eval_idx !== {IDX_W{1'b0}}) begin
         errors++; $display("FAIL areset flags: out_valid %0b busy %0b in_ready %0b idx %0d, expected 0 0 1 0", out_valid, busy, in_ready, eval_idx);
      end
      checks++; if (out_vec !== {OUT_W{1'b0}} || eval_vec !== {IN_W{1'b0}}) begin
         errors++; $display("FAIL areset vectors: out_vec %h eval_vec low %h, expected zero", out_vec, eval_vec[OUT_W-1:0]);
      end
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (out_valid === 1'b1) seen++;
      end
      checks++; if (seen != 0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL areset release: out_valid seen %0d in_ready %0b busy %0b, expected 0 1 0", seen, in_ready, busy);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
